// File: rtl/pipe_msg_pkg.sv
// Shared pipe message definitions for the portal pipe width converters.
// Used by both the serializer and the inverse deserializer.
package pipe_msg_pkg;

    localparam int PIPE_WIDTH    = 32;
    localparam int PIPE_WORDS    = 3;
    localparam int PIPE_MSG_BITS = PIPE_WIDTH * PIPE_WORDS;

    localparam int TAG_WORD  = 0;
    localparam int METH_WORD = 1;
    localparam int V_WORD    = 2;

    typedef logic [PIPE_MSG_BITS-1:0] pipe_msg_t;

    function automatic logic [PIPE_WIDTH-1:0] msg_word(pipe_msg_t m, int k);
        return m[k*PIPE_WIDTH +: PIPE_WIDTH];
    endfunction

endpackage

// File: rtl/pipe_msg_fifo.sv
// DEPTH-entry register FIFO of whole pipe messages.
// Writes while full and reads while empty are ignored.
module pipe_msg_fifo
    import pipe_msg_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int W     = PIPE_MSG_BITS
) (
    input  logic         CLK,
    input  logic         nRST,
    input  logic         enq,
    input  logic [W-1:0] enq_data,
    input  logic         deq,
    output logic [W-1:0] deq_data,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic [AW:0]   count;
    logic          do_enq;
    logic          do_deq;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_enq   = enq & ~full;
    assign do_deq   = deq & ~empty;
    assign deq_data = mem[rp];

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_enq) begin
                mem[wp] <= enq_data;
                wp      <= wp + 1'b1;
            end
            if (do_deq) begin
                rp <= rp + 1'b1;
            end
            unique case ({do_enq, do_deq})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pipe_msg_serializer.sv
// Transmit-side converter: buffers whole pipe messages and streams
// them out as WIDTH-bit beats with a last-beat marker.
module pipe_msg_serializer
    import pipe_msg_pkg::*;
#(
    parameter int WIDTH = PIPE_WIDTH,
    parameter int WORDS = PIPE_WORDS,
    parameter int DEPTH = 2,
    parameter int CNTW  = 16
) (
    input  logic                   CLK,
    input  logic                   nRST,
    input  logic                   pipe_enq__ENA,
    input  logic [WIDTH*WORDS-1:0] pipe_enq_v,
    output logic                   pipe_enq__RDY,
    output logic                   beat_enq__ENA,
    output logic [WIDTH-1:0]       beat_enq_v,
    output logic                   beat_enq_last,
    input  logic                   beat_enq__RDY,
    output logic [CNTW-1:0]        sent_count
);

    localparam int MSGW = WIDTH * WORDS;
    localparam int IW   = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

    logic [MSGW-1:0] head;
    logic            full;
    logic            empty;
    logic            pop;
    logic [IW-1:0]   idx;
    logic [IW-1:0]   idx_nxt;
    logic [CNTW-1:0] cnt_nxt;

    pipe_msg_fifo #(
        .DEPTH (DEPTH),
        .W     (MSGW)
    ) u_fifo (
        .CLK      (CLK),
        .nRST     (nRST),
        .enq      (pipe_enq__ENA),
        .enq_data (pipe_enq_v),
        .deq      (pop),
        .deq_data (head),
        .full     (full),
        .empty    (empty)
    );

    assign pipe_enq__RDY = nRST & ~full;
    assign beat_enq__ENA = ~empty & beat_enq__RDY;
    assign beat_enq_v    = head[int'(idx)*WIDTH +: WIDTH];
    assign beat_enq_last = (idx == LAST_IDX);

    // IDLE/STREAM is simply empty/!empty; idx walks the head message.
    always_comb begin
        idx_nxt = idx;
        cnt_nxt = sent_count;
        pop     = 1'b0;
        if (beat_enq__ENA) begin
            if (idx != LAST_IDX) begin
                idx_nxt = idx + 1'b1;
            end else begin
                idx_nxt = '0;
                pop     = 1'b1;
                cnt_nxt = sent_count + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            idx        <= '0;
            sent_count <= '0;
        end else begin
            idx        <= idx_nxt;
            sent_count <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_pipe_msg_serializer.sv
// Directed bench for pipe_msg_serializer: beat order, stalls, fill,
// push/pop overlap, async reset and counter wrap (CNTW=4).
module tb_pipe_msg_serializer;
    import pipe_msg_pkg::*;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        p_ena;
    logic [95:0] p_v;
    logic        p_rdy;
    logic        b_ena;
    logic [31:0] b_data;
    logic        b_last;
    logic        b_rdy;
    logic [3:0]  sent_count;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    logic [31:0] got_d[$];
    logic        got_l[$];
    int          got_c[$];

    pipe_msg_serializer #(
        .WIDTH (32),
        .WORDS (3),
        .DEPTH (2),
        .CNTW  (4)
    ) dut (
        .CLK           (CLK),
        .nRST          (nRST),
        .pipe_enq__ENA (p_ena),
        .pipe_enq_v    (p_v),
        .pipe_enq__RDY (p_rdy),
        .beat_enq__ENA (b_ena),
        .beat_enq_v    (b_data),
        .beat_enq_last (b_last),
        .beat_enq__RDY (b_rdy),
        .sent_count    (sent_count)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(string tag, logic [95:0] got, logic [95:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // A beat seen at a negedge transfers on the following posedge.
    always @(negedge CLK) begin
        if (nRST && b_ena) begin
            got_d.push_back(b_data);
            got_l.push_back(b_last);
            got_c.push_back(cyc);
        end
        if (nRST && p_ena) check("enq_protocol", p_rdy, 1);
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic pipe_msg_t mk(logic [31:0] t, logic [31:0] m, logic [31:0] v);
        return {v, m, t};
    endfunction

    task automatic enq(pipe_msg_t m);
        int n = 0;
        while (!p_rdy && n < 50) begin
            tick();
            n++;
        end
        if (!p_rdy) begin
            check("enq_timeout", 0, 1);
        end else begin
            p_ena = 1'b1;
            p_v   = m;
            tick();
            p_ena = 1'b0;
        end
    endtask

    task automatic check_stream(string tag, logic [31:0] exp[$], int c0);
        int n;
        check({tag, "_count"}, got_d.size(), exp.size());
        n = (got_d.size() < exp.size()) ? got_d.size() : exp.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_data%0d", tag, i), got_d[i], exp[i]);
            check($sformatf("%s_last%0d", tag, i), got_l[i], (i % 3) == 2);
            if (c0 >= 0) check($sformatf("%s_cyc%0d", tag, i), got_c[i], c0 + i);
        end
        got_d.delete();
        got_l.delete();
        got_c.delete();
    endtask

    initial begin
        logic [31:0] q[$];
        pipe_msg_t   m;
        int          e;
        int          n;
        int          pat[5];

        nRST  = 1'b0;
        p_ena = 1'b0;
        p_v   = '0;
        b_rdy = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_pipe_rdy", p_rdy, 0);
        check("rst_beat_ena", b_ena, 0);
        check("rst_count", sent_count, 0);
        nRST = 1'b1;
        tick();
        check("post_rst_pipe_rdy", p_rdy, 1);
        check("post_rst_beat_ena", b_ena, 0);

        // Single message
        b_rdy = 1'b1;
        m = mk(32'h1, 32'h11, 32'h22);
        check("pkg_tag_word", msg_word(m, TAG_WORD), 32'h1);
        enq(m);
        e = cyc;
        repeat (4) tick();
        q = '{32'h1, 32'h11, 32'h22};
        check_stream("single", q, e);
        check("single_cnt", sent_count, 1);

        // Backpressure: RDY 1,0,0,1,1
        pat = '{1, 0, 0, 1, 1};
        enq(m);
        for (int i = 0; i < 5; i++) begin
            b_rdy = pat[i][0];
            @(negedge CLK);
            if (pat[i] == 0) begin
                check($sformatf("bp_hold%0d", i), b_data, 32'h11);
                check($sformatf("bp_ena%0d", i), b_ena, 0);
            end
            tick();
        end
        repeat (2) tick();
        check_stream("bp", q, -1);
        check("bp_cnt", sent_count, 2);

        // Fill with downstream stalled
        b_rdy = 1'b0;
        enq(mk(32'hA0, 32'hA1, 32'hA2));
        check("fill_rdy_one", p_rdy, 1);
        enq(mk(32'hB0, 32'hB1, 32'hB2));
        check("fill_rdy_full", p_rdy, 0);
        b_rdy = 1'b1;
        e = cyc;
        repeat (3) @(negedge CLK);
        check("fill_rdy_hold", p_rdy, 0);
        tick();
        check("fill_rdy_rise", p_rdy, 1);
        repeat (4) tick();
        q = '{32'hA0, 32'hA1, 32'hA2, 32'hB0, 32'hB1, 32'hB2};
        check_stream("fill", q, e);
        check("fill_cnt", sent_count, 4);

        // Push on the cycle of the last beat
        enq(mk(32'hC0, 32'hC1, 32'hC2));
        e = cyc;
        repeat (2) tick();
        enq(mk(32'hD0, 32'hD1, 32'hD2));
        repeat (4) tick();
        q = '{32'hC0, 32'hC1, 32'hC2, 32'hD0, 32'hD1, 32'hD2};
        check_stream("simul", q, e);
        check("simul_cnt", sent_count, 6);

        // Async reset after beat 1
        enq(mk(32'hE0, 32'hE1, 32'hE2));
        e = cyc;
        repeat (2) tick();
        #2;
        nRST = 1'b0;
        #1;
        check("mid_rst_ena", b_ena, 0);
        check("mid_rst_pipe_rdy", p_rdy, 0);
        check("mid_rst_cnt", sent_count, 0);
        repeat (2) @(posedge CLK);
        #1;
        nRST = 1'b1;
        repeat (5) tick();
        check("mid_rst_idle", b_ena, 0);
        q = '{32'hE0, 32'hE1};
        check_stream("mid_rst", q, e);
        check("mid_rst_cnt_after", sent_count, 0);

        // 17 messages wrap the 4-bit counter; message 0 has tag 0
        q.delete();
        for (int i = 0; i < 17; i++) begin
            enq(mk(32'(i), 32'h100 + 32'(i), 32'h200 + 32'(i)));
            q.push_back(32'(i));
            q.push_back(32'h100 + 32'(i));
            q.push_back(32'h200 + 32'(i));
        end
        n = 0;
        while (got_d.size() < 51 && n < 300) begin
            tick();
            n++;
        end
        tick();
        check_stream("wrap", q, -1);
        check("wrap_cnt", sent_count, 1);
        check("wrap_idle", b_ena, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pipe_msg_serializer.md
Name: pipe_msg_serializer

Overview:
- Transmit-side width converter for the portal pipe.
- Accepts complete tagged 96-bit pipe messages (tag word plus argument words, as produced by the *RequestOutput / *IndicationOutput encoders) on a guarded pipe$enq method.
- Emits each message as a sequence of 32-bit beats toward the narrow host/portal channel, with a last-beat marker.
- Buffers up to DEPTH messages so the encoder is not stalled while a message is being streamed out.

Parameters:
- WIDTH, 32, beat width in bits.
- WORDS, 3, beats per message; message width is WIDTH*WORDS (96).
- DEPTH, 2, message buffer depth in entries; power of two, at least 2.
- CNTW, 16, width of the sent-message counter.

Ports:
- CLK  input  1  clock.
- nRST  input  1  asynchronous active-low reset.
- pipe$enq__ENA  input  1  message enqueue strobe; caller asserts it only while pipe$enq__RDY=1.
- pipe$enq$v  input  96  message; word k = v[32k+31:32k]; word 0 = tag, word 1 = meth, word 2 = v.
- pipe$enq__RDY  output  1  buffer can accept a message.
- beat$enq__ENA  output  1  beat transfer strobe toward the channel.
- beat$enq$v  output  32  current beat data.
- beat$enq$last  output  1  high on the final beat (word WORDS-1) of a message.
- beat$enq__RDY  input  1  channel can accept a beat.
- sent_count  output  CNTW  number of fully transmitted messages, modulo 2^CNTW.

Behaviour:
- Clocking and reset:
  - Single clock CLK; reset is asynchronous and active-low on nRST.
  - All state clears on nRST low, independent of CLK.
- Reset values:
  - Buffer empty; read/write pointers 0; beat index idx=0; sent_count=0.
  - pipe$enq__RDY=0 and beat$enq__ENA=0 while nRST=0.
  - beat$enq$v and beat$enq$last are don't-care while ENA=0.
- Input side:
  - pipe$enq__RDY = nRST & !full.
  - A message is written on every CLK edge where pipe$enq__ENA=1.
  - ENA with RDY=0 is a protocol violation; the bench flags it as an error and the design ignores the write.
- Output side:
  - beat$enq__ENA = !empty & beat$enq__RDY (combinational from RDY, guarded-method style).
  - beat$enq$v = head_msg word[idx].
  - beat$enq$last = (idx == WORDS-1).
- Beat sequencing (two-state view):
  - IDLE is empty; STREAM is !empty, with idx counting 0..WORDS-1.
  - On each CLK with beat$enq__ENA=1: if idx<WORDS-1, idx<=idx+1.
  - Otherwise (last beat): idx<=0, head entry popped, sent_count<=sent_count+1, wrapping at 2^CNTW.
  - beat$enq__RDY low holds idx and data stable; there are no bubbles inserted between beats of a message.
  - Back-to-back messages: the first beat of the next message follows the last beat of the previous one on the next cycle when RDY stays high.
- Latency:
  - A message written at edge t is presented as its word 0 beat in the cycle after edge t, because the buffer is registered.
  - Minimum message occupancy is WORDS cycles.
- Simultaneous events:
  - Push and last-beat pop in the same cycle, not full: both happen; occupancy is unchanged.
  - When full, RDY=0, so no push; the pop frees an entry and RDY rises the next cycle, not combinationally.
- Boundaries:
  - Pointers wrap modulo DEPTH.
  - full = (count==DEPTH); empty = (count==0); count is a log2(DEPTH)+1 bit occupancy register.
- Reset mid-message: the partially sent message and all buffered messages are discarded; no further beats after nRST deasserts until a new message is enqueued.
- Tag is not interpreted: every message, including tag 0, is transmitted.

Decomposition:
- Shared package pipe_msg_pkg:
  - Constants PIPE_WIDTH=32, PIPE_WORDS=3, PIPE_MSG_BITS=96.
  - Word index constants TAG_WORD=0, METH_WORD=1, V_WORD=2.
  - Typedef of the 96-bit message.
  - The inverse pipe_msg_deserializer reuses this package.
- Sub-module pipe_msg_fifo (DEPTH x 96 register FIFO, async active-low reset, enq/deq/full/empty).
- Top-level pipe_msg_serializer holds idx, the beat mux and sent_count.

Test Plan:
- Single message:
  - Stimulus: after reset release, enqueue v={32'h22,32'h11,32'h1} (word2,word1,word0), beat$enq__RDY=1.
  - Required: beats 0x1, 0x11, 0x22 on three consecutive cycles starting one cycle after the enqueue; last only on 0x22; sent_count=1.
- Backpressure:
  - Stimulus: same message, beat$enq__RDY toggled 1,0,0,1,1.
  - Required: beat 0x11 held stable through both stall cycles; no duplicate or dropped beats; total transfers = 3.
- Fill:
  - Stimulus: RDY=0 downstream, enqueue 2 messages.
  - Required: pipe$enq__RDY drops to 0 after the 2nd; releasing RDY yields 6 beats in order (msg A words 0..2, then msg B); pipe$enq__RDY returns to 1 the cycle after A's last beat.
- Simultaneous:
  - Stimulus: 1 message buffered; enqueue a new message on the cycle of its last beat.
  - Required: both accepted; the new message's word 0 appears the very next cycle; no gap.
- Reset mid-message:
  - Stimulus: drop nRST asynchronously (between edges) after beat 1 of a message, then release.
  - Required: beat$enq__ENA=0 immediately; sent_count=0; no beats until a new enqueue.
- Counter wrap:
  - Stimulus: CNTW=4 build, send 17 messages.
  - Required: sent_count reads 1; all 51 beats are correct.
